// File: rtl/collision_frame_detector.sv
// Per-frame sprite overlap counter that issues single-cycle collision pulses to the game FSM.
// Optional macro COLLISION_TARGET_ID_EN adds per-target bullet counters and a hit_target output.
module collision_frame_detector #(
    parameter int unsigned MIN_OVERLAP_PIXELS = 4,
    parameter int unsigned CNT_W              = 8,
    parameter int unsigned HOLDOFF_FRAMES     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       pixel_valid,
    input  logic       round_start,
    input  logic       target_1_rgb_en,
    input  logic       target_2_rgb_en,
    input  logic       target_3_rgb_en,
    input  logic       bullet_rgb_en,
    input  logic       spaceship_rgb_en,
    output logic       collision,
    output logic       collision_bullet,
`ifdef COLLISION_TARGET_ID_EN
    output logic [1:0] hit_target,
`endif
    output logic       armed
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] MIN_CNT   = CNT_W'(MIN_OVERLAP_PIXELS);
    localparam logic [3:0]       HOLD_INIT = 4'(HOLDOFF_FRAMES);
    localparam bit               HOLD_EN   = (HOLDOFF_FRAMES != 0);

    typedef enum logic {ARMED, HOLDOFF} state_t;

    state_t           state;
    logic [3:0]       holdoff_cnt;
    logic [CNT_W-1:0] ship_cnt;
    logic             any_t;
    logic             ship_ov;
    logic             ship_hit;
    logic             bul_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
        return (inc && (c != CNT_MAX)) ? c + CNT_W'(1) : c;
    endfunction

    assign any_t    = target_1_rgb_en | target_2_rgb_en | target_3_rgb_en;
    assign ship_ov  = spaceship_rgb_en & any_t & pixel_valid;
    assign ship_hit = (ship_cnt >= MIN_CNT);

`ifdef COLLISION_TARGET_ID_EN
    logic [CNT_W-1:0] bul_cnt [3];
    logic [2:0]       bul_ov_vec;
    logic [2:0]       bul_hit_vec;
    logic [1:0]       hit_id;

    assign bul_ov_vec = {3{bullet_rgb_en & pixel_valid}}
                      & {target_3_rgb_en, target_2_rgb_en, target_1_rgb_en};

    // Lowest-numbered target meeting the threshold wins the id.
    always_comb begin
        hit_id = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            bul_hit_vec[k] = (bul_cnt[k] >= MIN_CNT);
            if (bul_hit_vec[k]) hit_id = 2'(k + 1);
        end
    end
    assign bul_hit = |bul_hit_vec;
`else
    logic [CNT_W-1:0] bul_cnt;
    logic             bul_ov;

    assign bul_ov  = bullet_rgb_en & any_t & pixel_valid;
    assign bul_hit = (bul_cnt >= MIN_CNT);
`endif

    // round_start has priority over frame_start; a frame boundary reloads counters with the current pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= HOLD_EN ? HOLDOFF : ARMED;
            holdoff_cnt      <= HOLD_INIT;
            armed            <= !HOLD_EN;
            ship_cnt         <= '0;
            collision        <= 1'b0;
            collision_bullet <= 1'b0;
`ifdef COLLISION_TARGET_ID_EN
            hit_target       <= 2'd0;
            for (int k = 0; k < 3; k++) bul_cnt[k] <= '0;
`else
            bul_cnt          <= '0;
`endif
        end else begin
            collision        <= 1'b0;
            collision_bullet <= 1'b0;
`ifdef COLLISION_TARGET_ID_EN
            hit_target       <= 2'd0;
`endif
            if (round_start) begin
                ship_cnt    <= '0;
`ifdef COLLISION_TARGET_ID_EN
                for (int k = 0; k < 3; k++) bul_cnt[k] <= '0;
`else
                bul_cnt     <= '0;
`endif
                holdoff_cnt <= HOLD_INIT;
                state       <= HOLD_EN ? HOLDOFF : ARMED;
                armed       <= !HOLD_EN;
            end else if (frame_start) begin
                ship_cnt <= CNT_W'(ship_ov);
`ifdef COLLISION_TARGET_ID_EN
                for (int k = 0; k < 3; k++) bul_cnt[k] <= CNT_W'(bul_ov_vec[k]);
`else
                bul_cnt  <= CNT_W'(bul_ov);
`endif
                case (state)
                    ARMED: begin
                        collision        <= ship_hit;
                        collision_bullet <= bul_hit;
`ifdef COLLISION_TARGET_ID_EN
                        hit_target       <= hit_id;
`endif
                    end
                    HOLDOFF: begin
                        if (holdoff_cnt != 4'd0) holdoff_cnt <= holdoff_cnt - 4'd1;
                        if (holdoff_cnt <= 4'd1) begin
                            state <= ARMED;
                            armed <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ARMED;
                        armed <= 1'b1;
                    end
                endcase
            end else begin
                ship_cnt <= sat_inc(ship_cnt, ship_ov);
`ifdef COLLISION_TARGET_ID_EN
                for (int k = 0; k < 3; k++) bul_cnt[k] <= sat_inc(bul_cnt[k], bul_ov_vec[k]);
`else
                bul_cnt  <= sat_inc(bul_cnt, bul_ov);
`endif
            end
        end
    end

endmodule

// File: tb/tb_collision_frame_detector.sv
// Scoreboard bench for collision_frame_detector: expected outputs are queued per frame boundary.
module tb_collision_frame_detector;

    typedef struct packed {
        logic       col;
        logic       bul;
        logic [1:0] tgt;
        logic       arm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_start = 1'b0, pixel_valid = 1'b0, round_start = 1'b0;
    logic target_1_rgb_en = 1'b0, target_2_rgb_en = 1'b0, target_3_rgb_en = 1'b0;
    logic bullet_rgb_en = 1'b0, spaceship_rgb_en = 1'b0;
    logic collision, collision_bullet, armed;
    logic collision4, collision_bullet4, armed4;
    logic [1:0] tgt_obs, tgt_obs4;
    logic [4:0] obs, obs4;

    exp_t exp_q[$];
    exp_t e;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    collision_frame_detector dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pixel_valid(pixel_valid),
        .round_start(round_start), .target_1_rgb_en(target_1_rgb_en),
        .target_2_rgb_en(target_2_rgb_en), .target_3_rgb_en(target_3_rgb_en),
        .bullet_rgb_en(bullet_rgb_en), .spaceship_rgb_en(spaceship_rgb_en),
        .collision(collision), .collision_bullet(collision_bullet),
`ifdef COLLISION_TARGET_ID_EN
        .hit_target(tgt_obs),
`endif
        .armed(armed)
    );

    collision_frame_detector #(.MIN_OVERLAP_PIXELS(10), .CNT_W(4), .HOLDOFF_FRAMES(2)) dut4 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pixel_valid(pixel_valid),
        .round_start(round_start), .target_1_rgb_en(target_1_rgb_en),
        .target_2_rgb_en(target_2_rgb_en), .target_3_rgb_en(target_3_rgb_en),
        .bullet_rgb_en(bullet_rgb_en), .spaceship_rgb_en(spaceship_rgb_en),
        .collision(collision4), .collision_bullet(collision_bullet4),
`ifdef COLLISION_TARGET_ID_EN
        .hit_target(tgt_obs4),
`endif
        .armed(armed4)
    );

`ifndef COLLISION_TARGET_ID_EN
    assign tgt_obs  = 2'd0;
    assign tgt_obs4 = 2'd0;
`endif
    assign obs  = {collision, collision_bullet, tgt_obs, armed};
    assign obs4 = {collision4, collision_bullet4, tgt_obs4, armed4};

    // Target id is only observable when the feature is built in.
    function automatic logic [1:0] tid(input logic [1:0] k);
`ifdef COLLISION_TARGET_ID_EN
        return k;
`else
        return (k == 2'd0) ? 2'd0 : 2'd0;
`endif
    endfunction

    function automatic exp_t mk(input logic c, input logic b, input logic [1:0] t, input logic a);
        return '{col: c, bul: b, tgt: t, arm: a};
    endfunction

    // Drive n cycles of one pixel pattern; returns at a falling edge with inputs idle.
    task automatic drive(input int n, input logic fs, input logic rs, input logic pv,
                         input logic sh, input logic bu, input logic a, input logic b, input logic c);
        for (int i = 0; i < n; i++) begin
            frame_start = fs; round_start = rs; pixel_valid = pv;
            spaceship_rgb_en = sh; bullet_rgb_en = bu;
            target_1_rgb_en = a; target_2_rgb_en = b; target_3_rgb_en = c;
            @(negedge clk);
        end
        frame_start = 1'b0; round_start = 1'b0; pixel_valid = 1'b0;
        spaceship_rgb_en = 1'b0; bullet_rgb_en = 1'b0;
        target_1_rgb_en = 1'b0; target_2_rgb_en = 1'b0; target_3_rgb_en = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        exp_q.push_back(mk(0, 0, 2'd0, 0));
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL reset got=%b exp=%b", obs, e); end
        checks++;
        if (obs4 !== 5'(e)) begin failures++; $display("FAIL reset_w4 got=%b exp=%b", obs4, e); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_holdoff;
        exp_q.push_back(mk(0, 0, 2'd0, 0));
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL hold_f1 got=%b exp=%b", obs, e); end
        drive(10, 0, 0, 1, 0, 1, 1, 0, 0);
        exp_q.push_back(mk(0, 0, 2'd0, 1));
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL hold_f2 got=%b exp=%b", obs, e); end
        drive(10, 0, 0, 1, 0, 1, 1, 0, 0);
        exp_q.push_back(mk(0, 1, tid(2'd1), 1));
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL hold_f3 got=%b exp=%b", obs, e); end
        exp_q.push_back(mk(0, 0, 2'd0, 1));
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL hold_after got=%b exp=%b", obs, e); end
    endtask

    task automatic test_threshold;
        exp_q.push_back(mk(0, 0, 2'd0, 1));
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL thr_open got=%b exp=%b", obs, e); end
        drive(3, 0, 0, 1, 1, 0, 0, 1, 0);
        exp_q.push_back(mk(0, 0, 2'd0, 1));
        drive(1, 1, 0, 1, 1, 0, 0, 1, 0);   // frame_start pixel overlaps: first pixel of next frame
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL thr_3 got=%b exp=%b", obs, e); end
        drive(3, 0, 0, 1, 1, 0, 0, 1, 0);
        exp_q.push_back(mk(1, 0, 2'd0, 1));
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL thr_4 got=%b exp=%b", obs, e); end
        exp_q.push_back(mk(0, 0, 2'd0, 1));
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL thr_clear got=%b exp=%b", obs, e); end
    endtask

    task automatic test_both;
        drive(5, 0, 0, 1, 1, 1, 1, 0, 0);
        exp_q.push_back(mk(1, 1, tid(2'd1), 1));
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL both_pulse got=%b exp=%b", obs, e); end
        exp_q.push_back(mk(0, 0, 2'd0, 1));
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL both_low got=%b exp=%b", obs, e); end
    endtask

    task automatic test_saturate;
        drive(40, 0, 0, 1, 1, 0, 0, 0, 1);
        exp_q.push_back(mk(1, 0, 2'd0, 1));
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL sat_w8 got=%b exp=%b", obs, e); end
        checks++;
        if (obs4 !== 5'(e)) begin failures++; $display("FAIL sat_w4_nowrap got=%b exp=%b", obs4, e); end
        drive(20, 0, 0, 1, 0, 0, 1, 1, 1);
        exp_q.push_back(mk(0, 0, 2'd0, 1));
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs4 !== 5'(e)) begin failures++; $display("FAIL sat_w4_empty got=%b exp=%b", obs4, e); end
        drive(9, 0, 0, 1, 1, 0, 1, 0, 0);
        exp_q.push_back(mk(1, 0, 2'd0, 1));
        exp_q.push_back(mk(0, 0, 2'd0, 1));
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL sat_nine_w8 got=%b exp=%b", obs, e); end
        e = exp_q.pop_front(); checks++;
        if (obs4 !== 5'(e)) begin failures++; $display("FAIL sat_nine_w4 got=%b exp=%b", obs4, e); end
    endtask

    task automatic test_round_coincident;
        drive(6, 0, 0, 1, 0, 1, 1, 0, 0);
        exp_q.push_back(mk(0, 0, 2'd0, 0));
        drive(1, 1, 1, 1, 0, 1, 1, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL rc_coinc got=%b exp=%b", obs, e); end
        drive(20, 0, 0, 0, 1, 1, 1, 1, 1);
        exp_q.push_back(mk(0, 0, 2'd0, 0));
        drive(1, 1, 0, 0, 1, 1, 1, 1, 1);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL rc_hold1 got=%b exp=%b", obs, e); end
        drive(20, 0, 0, 0, 1, 1, 1, 1, 1);
        exp_q.push_back(mk(0, 0, 2'd0, 1));
        drive(1, 1, 0, 0, 1, 1, 1, 1, 1);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL rc_hold2 got=%b exp=%b", obs, e); end
        drive(20, 0, 0, 0, 1, 1, 1, 1, 1);
        exp_q.push_back(mk(0, 0, 2'd0, 1));
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL rc_invalid got=%b exp=%b", obs, e); end
    endtask

    task automatic test_target_id;
        drive(5, 0, 0, 1, 0, 1, 0, 0, 1);
        drive(5, 0, 0, 1, 0, 1, 0, 1, 0);
        exp_q.push_back(mk(0, 1, tid(2'd2), 1));
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL tid_pulse got=%b exp=%b", obs, e); end
        exp_q.push_back(mk(0, 0, 2'd0, 1));
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL tid_clear got=%b exp=%b", obs, e); end
    endtask

    task automatic test_reset_mid;
        drive(5, 0, 0, 1, 1, 0, 0, 1, 0);
        exp_q.push_back(mk(1, 0, 2'd0, 1));
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL rstmid_pre got=%b exp=%b", obs, e); end
        exp_q.push_back(mk(0, 0, 2'd0, 0));
        #2 rst = 1'b1;
        #1;
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL rstmid_drop got=%b exp=%b", obs, e); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_holdoff();
        test_threshold();
        test_both();
        test_saturate();
        test_round_coincident();
        test_target_id();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
